rs_bank_param: RTL

- Parametrised reservation-station bank with NUM_RS entries. Generalises the fixed, RS_sel-addressed station array.
- The bank allocates internally to a free slot. It snoops NUM_CDB broadcast buses and wakes up operands in every entry.
- Each cycle it selects the oldest ready entry and dispatches it to one functional unit over a valid/ready handshake.
- It sits between the instruction queue (issue side) and the ALU/functional unit. The ROB index is the instruction tag.

---
 rtl/rs_bank_param.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rs_bank_param.sv
// Parametrised reservation-station bank.
// Issue requests are written into the lowest free entry. Every entry snoops NUM_CDB
// broadcast buses to pick up missing operands. Each cycle the oldest entry with
// both operands is presented to the functional unit over a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   flush                synchronous squash of every entry
//   alloc_*              issue side: valid/ready, op, destination tag, two sources
//   cdb_valid/rob/value  NUM_CDB packed broadcast buses, bus k at [k*W +: W]
//   disp_*               dispatch side: valid/ready, op, destination tag, operands
//   occupancy            number of busy entries
module rs_bank_param #(
    parameter int NUM_RS    = 8,
    parameter int NUM_CDB   = 5,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 3,
    localparam int OCC_W    = $clog2(NUM_RS + 1),
    localparam int IDX_W    = $clog2(NUM_RS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [OP_W-1:0]              alloc_op,
    input  logic [ROB_IDX_W-1:0]         alloc_dest_rob,
    input  logic                         alloc_src1_valid,
    input  logic                         alloc_src2_valid,
    input  logic [ROB_IDX_W-1:0]         alloc_src1_rob,
    input  logic [ROB_IDX_W-1:0]         alloc_src2_rob,
    input  logic [DATA_W-1:0]            alloc_src1_value,
    input  logic [DATA_W-1:0]            alloc_src2_value,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_rob,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_value,
    output logic                         disp_valid,
    input  logic                         disp_ready,
    output logic [OP_W-1:0]              disp_op,
    output logic [ROB_IDX_W-1:0]         disp_dest_rob,
    output logic [DATA_W-1:0]            disp_src1,
    output logic [DATA_W-1:0]            disp_src2,
    output logic [OCC_W-1:0]             occupancy
);

    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_RS - 1);

    logic [NUM_RS-1:0]    busy_q, busy_d;
    logic [IDX_W-1:0]     age_q  [NUM_RS];
    logic [IDX_W-1:0]     age_d  [NUM_RS];
    logic [OP_W-1:0]      op_q   [NUM_RS];
    logic [OP_W-1:0]      op_d   [NUM_RS];
    logic [ROB_IDX_W-1:0] dest_q [NUM_RS];
    logic [ROB_IDX_W-1:0] dest_d [NUM_RS];
    logic [NUM_RS-1:0]    s1v_q, s1v_d, s2v_q, s2v_d;
    logic [ROB_IDX_W-1:0] s1r_q  [NUM_RS];
    logic [ROB_IDX_W-1:0] s1r_d  [NUM_RS];
    logic [ROB_IDX_W-1:0] s2r_q  [NUM_RS];
    logic [ROB_IDX_W-1:0] s2r_d  [NUM_RS];
    logic [DATA_W-1:0]    s1d_q  [NUM_RS];
    logic [DATA_W-1:0]    s1d_d  [NUM_RS];
    logic [DATA_W-1:0]    s2d_q  [NUM_RS];
    logic [DATA_W-1:0]    s2d_d  [NUM_RS];

    logic [OCC_W-1:0]  occ_cnt;
    logic [IDX_W-1:0]  free_idx;
    logic [NUM_RS-1:0] rdy;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  sel_age;
    logic              alloc_fire, disp_fire;
    logic              byp1_hit, byp2_hit;
    logic [DATA_W-1:0] byp1_val, byp2_val;

    // Occupancy, free slot (lowest index wins), ready vector and oldest-ready select.
    always_comb begin
        occ_cnt   = '0;
        free_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        rdy       = busy_q & s1v_q & s2v_q;
        for (int i = 0; i < NUM_RS; i++) begin
            occ_cnt = occ_cnt + {{(OCC_W-1){1'b0}}, busy_q[i]};
        end
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_RS; i++) begin
            if (rdy[i] && (!sel_found || age_q[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    assign occupancy   = occ_cnt;
    assign alloc_ready = (occ_cnt != OCC_W'(NUM_RS));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign disp_valid  = sel_found;
    assign disp_fire   = sel_found && disp_ready;

    assign disp_op       = sel_found ? op_q[sel_idx]   : '0;
    assign disp_dest_rob = sel_found ? dest_q[sel_idx] : '0;
    assign disp_src1     = sel_found ? s1d_q[sel_idx]  : '0;
    assign disp_src2     = sel_found ? s2d_q[sel_idx]  : '0;

    // Same-cycle CDB capture for incoming sources; scanning downwards lets bus 0 win.
    always_comb begin
        byp1_hit = 1'b0;
        byp2_hit = 1'b0;
        byp1_val = '0;
        byp2_val = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_rob[k*ROB_IDX_W +: ROB_IDX_W] == alloc_src1_rob) begin
                byp1_hit = 1'b1;
                byp1_val = cdb_value[k*DATA_W +: DATA_W];
            end
            if (cdb_valid[k] && cdb_rob[k*ROB_IDX_W +: ROB_IDX_W] == alloc_src2_rob) begin
                byp2_hit = 1'b1;
                byp2_val = cdb_value[k*DATA_W +: DATA_W];
            end
        end
    end

    // Age of a busy entry = number of younger busy entries. Allocation bumps every
    // other busy entry; a dispatch pulls down the entries older than the one leaving,
    // so ages stay unique and below NUM_RS.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        op_d   = op_q;
        dest_d = dest_q;
        s1v_d  = s1v_q;
        s2v_d  = s2v_q;
        s1r_d  = s1r_q;
        s2r_d  = s2r_q;
        s1d_d  = s1d_q;
        s2d_d  = s2d_q;
        for (int i = 0; i < NUM_RS; i++) begin
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (busy_q[i] && cdb_valid[k]) begin
                    if (!s1v_q[i] && cdb_rob[k*ROB_IDX_W +: ROB_IDX_W] == s1r_q[i]) begin
                        s1v_d[i] = 1'b1;
                        s1d_d[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                    if (!s2v_q[i] && cdb_rob[k*ROB_IDX_W +: ROB_IDX_W] == s2r_q[i]) begin
                        s2v_d[i] = 1'b1;
                        s2d_d[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                end
            end
            if (busy_q[i]) begin
                if (disp_fire && sel_idx == IDX_W'(i)) begin
                    busy_d[i] = 1'b0;
                    age_d[i]  = '0;
                end else if (alloc_fire && !(disp_fire && age_q[i] > sel_age)) begin
                    if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
                end else if (!alloc_fire && disp_fire && age_q[i] > sel_age) begin
                    age_d[i] = age_q[i] - 1'b1;
                end
            end else if (alloc_fire && free_idx == IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                age_d[i]  = '0;
                op_d[i]   = alloc_op;
                dest_d[i] = alloc_dest_rob;
                s1r_d[i]  = alloc_src1_rob;
                s2r_d[i]  = alloc_src2_rob;
                s1v_d[i]  = alloc_src1_valid || byp1_hit;
                s2v_d[i]  = alloc_src2_valid || byp2_hit;
                s1d_d[i]  = alloc_src1_valid ? alloc_src1_value : byp1_val;
                s2d_d[i]  = alloc_src2_valid ? alloc_src2_value : byp2_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_RS; i++) age_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
        end
    end

    // Payload fields are only meaningful while busy, so they need no reset.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        dest_q <= dest_d;
        s1v_q  <= s1v_d;
        s2v_q  <= s2v_d;
        s1r_q  <= s1r_d;
        s2r_q  <= s2r_d;
        s1d_q  <= s1d_d;
        s2d_q  <= s2d_d;
    end

endmodule
